// File: rtl/dram_fifo_responder_if.sv
// Handshake bundle between the ORAM core (master) and the DRAM-side
// responder (slave).
//   address / command / command_valid / command_ready : burst command channel
//   write_data / write_mask / write_data_valid / write_data_ready : write beats
//   read_data / read_data_valid : read beats, no backpressure
interface dram_fifo_responder_if #(
    parameter int DWidth = 64,
    parameter int AWidth = 30,
    parameter int CWidth = 3,
    parameter int MWidth = 8
);
    logic [AWidth-1:0] address;
    logic [CWidth-1:0] command;
    logic              command_valid;
    logic              command_ready;
    logic [DWidth-1:0] write_data;
    logic [MWidth-1:0] write_mask;
    logic              write_data_valid;
    logic              write_data_ready;
    logic [DWidth-1:0] read_data;
    logic              read_data_valid;

    modport master (
        output address, command, command_valid, write_data, write_mask, write_data_valid,
        input  command_ready, write_data_ready, read_data, read_data_valid
    );

    modport slave (
        input  address, command, command_valid, write_data, write_mask, write_data_valid,
        output command_ready, write_data_ready, read_data, read_data_valid
    );
endinterface

// File: rtl/dram_fifo_responder.sv
// DRAM-side responder standing in for the DDR controller. Accepts burst
// read/write commands, keeps data in an on-chip RAM and returns read bursts
// a fixed number of cycles after the command is accepted.
//   clk   : single clock
//   rst_n : asynchronous active-low reset (RAM contents are kept)
//   bus   : slave side of dram_fifo_responder_if (command, write, read channels)
//
// state | meaning
// IDLE  | command_ready high, waiting for a command
// WRITE | accepting BurstLen write beats
// RLAT  | read latency countdown
// READ  | streaming BurstLen read beats
module dram_fifo_responder #(
    parameter int DWidth       = 64,
    parameter int AWidth       = 30,
    parameter int CWidth       = 3,
    parameter int MWidth       = 8,
    parameter int BurstLen     = 8,
    parameter int MemDepthLog2 = 12,
    parameter int ReadLatency  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dram_fifo_responder_if.slave bus
);
    localparam int BLog2 = $clog2(BurstLen);
    localparam int LatW  = (ReadLatency > 2) ? $clog2(ReadLatency - 1) : 1;
    // The entry edge and the edge that raises read_data_valid account for
    // two of the latency cycles, so the countdown starts at ReadLatency-2.
    localparam logic [LatW-1:0]   LatLoad  = LatW'((ReadLatency > 1) ? ReadLatency - 2 : 0);
    localparam logic [BLog2-1:0]  LastBeat = BLog2'(BurstLen - 1);
    localparam logic [CWidth-1:0] CmdWrite = CWidth'(0);
    localparam logic [CWidth-1:0] CmdRead  = CWidth'(1);

    typedef enum logic [1:0] {IDLE, WRITE, RLAT, READ} state_t;

    state_t                          state;
    logic                            cmd_ready;
    logic                            wr_ready;
    logic                            rd_valid;
    logic [DWidth-1:0]               rd_data;
    logic [BLog2-1:0]                beat_cnt;
    logic [LatW-1:0]                 lat_cnt;
    logic [MemDepthLog2-BLog2-1:0]   base_blk;

    logic [DWidth-1:0] mem [0:(1 << MemDepthLog2) - 1];

    // Burst-aligned block of the incoming address; low beat bits and bits
    // above the RAM depth are dropped, so the index wraps naturally.
    logic [MemDepthLog2-BLog2-1:0] cmd_blk;
    logic [BLog2-1:0]              beat_next;
    logic                          wr_fire;
    logic                          cmd_fire;

    assign cmd_blk   = bus.address[MemDepthLog2-1:BLog2];
    assign beat_next = beat_cnt + 1'b1;
    assign wr_fire   = wr_ready & bus.write_data_valid;
    assign cmd_fire  = cmd_ready & bus.command_valid;

    assign bus.command_ready    = cmd_ready;
    assign bus.write_data_ready = wr_ready;
    assign bus.read_data_valid  = rd_valid;
    assign bus.read_data        = rd_data;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < MWidth; i++) begin
                if (!bus.write_mask[i])
                    mem[{base_blk, beat_cnt}][i*8 +: 8] <= bus.write_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            beat_cnt  <= '0;
            lat_cnt   <= '0;
            base_blk  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        base_blk <= cmd_blk;
                        beat_cnt <= '0;
                        if (bus.command == CmdWrite) begin
                            state     <= WRITE;
                            cmd_ready <= 1'b0;
                            wr_ready  <= 1'b1;
                        end else if (bus.command == CmdRead) begin
                            cmd_ready <= 1'b0;
                            if (ReadLatency == 1) begin
                                state    <= READ;
                                rd_valid <= 1'b1;
                                rd_data  <= mem[{cmd_blk, BLog2'(0)}];
                            end else begin
                                state   <= RLAT;
                                lat_cnt <= LatLoad;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (wr_fire) begin
                        if (beat_cnt == LastBeat) begin
                            state     <= IDLE;
                            wr_ready  <= 1'b0;
                            cmd_ready <= 1'b1;
                        end else begin
                            beat_cnt <= beat_next;
                        end
                    end
                end
                RLAT: begin
                    if (lat_cnt == '0) begin
                        state    <= READ;
                        rd_valid <= 1'b1;
                        rd_data  <= mem[{base_blk, beat_cnt}];
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                READ: begin
                    if (beat_cnt == LastBeat) begin
                        state     <= IDLE;
                        rd_valid  <= 1'b0;
                        rd_data   <= '0;
                        cmd_ready <= 1'b1;
                    end else begin
                        beat_cnt <= beat_next;
                        rd_data  <= mem[{base_blk, beat_next}];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
